// File: rtl/mips_control_sequencer.sv
// -----------------------------------------------------------------------------
// mips_control_sequencer
//
// Next-state engine for the multi-cycle MIPS32 control unit. Holds the current
// control-state number and walks it through the ten-state fetch / decode /
// execute FSM using the instruction opcode. The state bus feeds the existing
// combinational control-signal decoder (its op input). On top of the classic
// FSM this block adds memory-wait stalling, run/halt gating, illegal-opcode
// detection and a retired-instruction counter.
//
// Ports:
//   clk           in   rising-edge system clock
//   reset         in   synchronous, active-high reset (dominates everything)
//   run           in   1 = sequencer may advance, 0 = freeze all state
//   opcode        in   instruction[31:26], sampled only in decode / mem-address
//   mem_ready     in   memory completed this cycle's access
//   state         out  current control state (to decoder op input)
//   illegal_op    out  one-cycle pulse when decode sees an unsupported opcode
//   halted        out  sticky halt flag (only ever set when HALT_ON_ILLEGAL=1)
//   instr_retired out  count of completed instructions, wraps modulo 2^COUNT_W
// -----------------------------------------------------------------------------
module mips_control_sequencer #(
    parameter int STATE_W         = 6,
    parameter int COUNT_W         = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] state,
    output logic               illegal_op,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_retired
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        R_EXEC   = STATE_W'(2),
        R_WB     = STATE_W'(3),
        BEQ_EXEC = STATE_W'(4),
        MEM_ADDR = STATE_W'(5),
        SW_WRITE = STATE_W'(6),
        LW_READ  = STATE_W'(7),
        LW_WB    = STATE_W'(8),
        JUMP     = STATE_W'(9)
    } ctrlState_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    ctrlState_t curState;

    assign state = curState;

    always_ff @(posedge clk) begin
        if (reset) begin
            curState      <= FETCH;
            illegal_op    <= 1'b0;
            halted        <= 1'b0;
            instr_retired <= '0;
        end else begin
            // illegal_op is a pulse: cleared every cycle unless decode re-raises it
            illegal_op <= 1'b0;
            // run=0 or a sticky halt freezes everything, including pending mem_ready
            if (run && !halted) begin
                case (curState)
                    FETCH: begin
                        if (mem_ready) curState <= DECODE;
                    end
                    DECODE: begin
                        case (opcode)
                            OP_RTYPE:     curState <= R_EXEC;
                            OP_LW, OP_SW: curState <= MEM_ADDR;
                            OP_BEQ:       curState <= BEQ_EXEC;
                            OP_J:         curState <= JUMP;
                            default: begin
                                // Unsupported opcode: abandon the instruction
                                // without retiring it; optionally stop for good.
                                curState   <= FETCH;
                                illegal_op <= 1'b1;
                                if (HALT_ON_ILLEGAL) halted <= 1'b1;
                            end
                        endcase
                    end
                    R_EXEC: curState <= R_WB;
                    R_WB: begin
                        curState      <= FETCH;
                        instr_retired <= instr_retired + COUNT_W'(1);
                    end
                    BEQ_EXEC: begin
                        curState      <= FETCH;
                        instr_retired <= instr_retired + COUNT_W'(1);
                    end
                    MEM_ADDR: begin
                        // Decode only lets LW/SW in here; anything else means the
                        // instruction register changed underneath us, so refetch.
                        if (opcode == OP_LW)      curState <= LW_READ;
                        else if (opcode == OP_SW) curState <= SW_WRITE;
                        else                      curState <= FETCH;
                    end
                    SW_WRITE: begin
                        if (mem_ready) begin
                            curState      <= FETCH;
                            instr_retired <= instr_retired + COUNT_W'(1);
                        end
                    end
                    LW_READ: begin
                        if (mem_ready) curState <= LW_WB;
                    end
                    LW_WB: begin
                        curState      <= FETCH;
                        instr_retired <= instr_retired + COUNT_W'(1);
                    end
                    JUMP: begin
                        curState      <= FETCH;
                        instr_retired <= instr_retired + COUNT_W'(1);
                    end
                    // Unreachable encodings recover silently to fetch
                    default: curState <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mips_control_sequencer
//
// Two instances share the stimulus: dutA skips illegal opcodes and uses a
// 4-bit counter (to reach the wrap quickly), dutB halts on illegal opcodes and
// keeps the full 32-bit counter. Each scenario task builds a per-cycle table of
// inputs plus the expected dutA outputs after the next edge; the expectation is
// pushed to a scoreboard queue as the inputs are driven and popped once the
// edge has happened.
// -----------------------------------------------------------------------------
module tb_mips_control_sequencer;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    localparam logic [5:0] S_FETCH  = 6'd0;
    localparam logic [5:0] S_DECODE = 6'd1;
    localparam logic [5:0] S_REXEC  = 6'd2;
    localparam logic [5:0] S_RWB    = 6'd3;
    localparam logic [5:0] S_BEQ    = 6'd4;
    localparam logic [5:0] S_MADDR  = 6'd5;
    localparam logic [5:0] S_SWWR   = 6'd6;
    localparam logic [5:0] S_LWRD   = 6'd7;
    localparam logic [5:0] S_LWWB   = 6'd8;
    localparam logic [5:0] S_JUMP   = 6'd9;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        mem_ready;
    logic [5:0]  opcode;

    logic [5:0]  stateA, stateB;
    logic        illA, illB, haltA, haltB;
    logic [3:0]  cntA;
    logic [31:0] cntB;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       rn;
        logic       mr;
        logic [5:0] op;
        logic [5:0] st;
        logic       ill;
        logic [3:0] cnt;
    } cyc_t;

    typedef struct {
        logic [5:0] st;
        logic       ill;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mips_control_sequencer #(
        .STATE_W(6), .COUNT_W(4), .HALT_ON_ILLEGAL(1'b0)
    ) dutA (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .state(stateA), .illegal_op(illA), .halted(haltA), .instr_retired(cntA)
    );

    mips_control_sequencer #(
        .STATE_W(6), .COUNT_W(32), .HALT_ON_ILLEGAL(1'b1)
    ) dutB (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .state(stateB), .illegal_op(illB), .halted(haltB), .instr_retired(cntB)
    );

    function automatic cyc_t cy(logic r, logic rn, logic mr, logic [5:0] op,
                                logic [5:0] st, logic ill, logic [3:0] cnt);
        cyc_t c;
        c.rst = r; c.rn = rn; c.mr = mr; c.op = op;
        c.st = st; c.ill = ill; c.cnt = cnt;
        return c;
    endfunction

    // Drive one cycle of stimulus, record its expectation, and move past the edge.
    task automatic apply_cycle(input cyc_t c);
        exp_t e;
        reset     = c.rst;
        run       = c.rn;
        mem_ready = c.mr;
        opcode    = c.op;
        e.st = c.st; e.ill = c.ill; e.cnt = c.cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = OP_R;
        @(posedge clk);
        #1;
        checks++;
        if (stateA !== 6'd0 || illA !== 1'b0 || haltA !== 1'b0 || cntA !== 4'd0) begin
            errors++;
            $display("FAIL reset_A: got st=%0d ill=%b halt=%b cnt=%0d, want st=0 ill=0 halt=0 cnt=0",
                     stateA, illA, haltA, cntA);
        end
        checks++;
        if (stateB !== 6'd0 || illB !== 1'b0 || haltB !== 1'b0 || cntB !== 32'd0) begin
            errors++;
            $display("FAIL reset_B: got st=%0d ill=%b halt=%b cnt=%0d, want st=0 ill=0 halt=0 cnt=0",
                     stateB, illB, haltB, cntB);
        end
        reset = 1'b0;
    endtask

    task automatic test_r_type();
        cyc_t cs[$];
        exp_t e;
        cs.push_back(cy(0, 1, 1, OP_R, S_DECODE, 0, 0));
        cs.push_back(cy(0, 1, 1, OP_R, S_REXEC,  0, 0));
        cs.push_back(cy(0, 1, 1, OP_R, S_RWB,    0, 0));
        cs.push_back(cy(0, 1, 1, OP_R, S_FETCH,  0, 1));
        foreach (cs[i]) begin
            apply_cycle(cs[i]);
            e = sb.pop_front();
            checks++;
            if (stateA !== e.st || illA !== e.ill || cntA !== e.cnt || haltA !== 1'b0) begin
                errors++;
                $display("FAIL r_type cyc%0d: got st=%0d ill=%b cnt=%0d halt=%b, want st=%0d ill=%b cnt=%0d halt=0",
                         i, stateA, illA, cntA, haltA, e.st, e.ill, e.cnt);
            end
        end
    endtask

    task automatic test_lw_stall();
        cyc_t cs[$];
        exp_t e;
        cs.push_back(cy(0, 1, 1, OP_LW, S_DECODE, 0, 1));
        cs.push_back(cy(0, 1, 1, OP_LW, S_MADDR,  0, 1));
        cs.push_back(cy(0, 1, 1, OP_LW, S_LWRD,   0, 1));
        cs.push_back(cy(0, 1, 0, OP_LW, S_LWRD,   0, 1));
        cs.push_back(cy(0, 1, 0, OP_LW, S_LWRD,   0, 1));
        cs.push_back(cy(0, 1, 0, OP_LW, S_LWRD,   0, 1));
        cs.push_back(cy(0, 1, 1, OP_LW, S_LWWB,   0, 1));
        cs.push_back(cy(0, 1, 1, OP_LW, S_FETCH,  0, 2));
        foreach (cs[i]) begin
            apply_cycle(cs[i]);
            e = sb.pop_front();
            checks++;
            if (stateA !== e.st || illA !== e.ill || cntA !== e.cnt || haltA !== 1'b0) begin
                errors++;
                $display("FAIL lw_stall cyc%0d: got st=%0d ill=%b cnt=%0d halt=%b, want st=%0d ill=%b cnt=%0d halt=0",
                         i, stateA, illA, cntA, haltA, e.st, e.ill, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc_t cs[$];
        exp_t e;
        // SW with one memory wait (opcode garbage during the wait is don't-care)
        cs.push_back(cy(0, 1, 1, OP_SW,  S_DECODE, 0, 2));
        cs.push_back(cy(0, 1, 1, OP_SW,  S_MADDR,  0, 2));
        cs.push_back(cy(0, 1, 1, OP_SW,  S_SWWR,   0, 2));
        cs.push_back(cy(0, 1, 0, OP_BAD, S_SWWR,   0, 2));
        cs.push_back(cy(0, 1, 1, OP_SW,  S_FETCH,  0, 3));
        // BEQ
        cs.push_back(cy(0, 1, 1, OP_BEQ, S_DECODE, 0, 3));
        cs.push_back(cy(0, 1, 1, OP_BEQ, S_BEQ,    0, 3));
        cs.push_back(cy(0, 1, 1, OP_BEQ, S_FETCH,  0, 4));
        // J
        cs.push_back(cy(0, 1, 1, OP_J,   S_DECODE, 0, 4));
        cs.push_back(cy(0, 1, 1, OP_J,   S_JUMP,   0, 4));
        cs.push_back(cy(0, 1, 1, OP_J,   S_FETCH,  0, 5));
        foreach (cs[i]) begin
            apply_cycle(cs[i]);
            e = sb.pop_front();
            checks++;
            if (stateA !== e.st || illA !== e.ill || cntA !== e.cnt || haltA !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back cyc%0d: got st=%0d ill=%b cnt=%0d halt=%b, want st=%0d ill=%b cnt=%0d halt=0",
                         i, stateA, illA, cntA, haltA, e.st, e.ill, e.cnt);
            end
        end
    endtask

    task automatic test_illegal();
        cyc_t cs[$];
        exp_t e;
        cs.push_back(cy(0, 1, 1, OP_BAD, S_DECODE, 0, 5));
        cs.push_back(cy(0, 1, 1, OP_BAD, S_FETCH,  1, 5));
        cs.push_back(cy(0, 1, 0, OP_R,   S_FETCH,  0, 5));
        cs.push_back(cy(0, 1, 1, OP_R,   S_DECODE, 0, 5));
        cs.push_back(cy(0, 1, 1, OP_R,   S_REXEC,  0, 5));
        cs.push_back(cy(0, 1, 1, OP_R,   S_RWB,    0, 5));
        cs.push_back(cy(0, 1, 1, OP_R,   S_FETCH,  0, 6));
        foreach (cs[i]) begin
            apply_cycle(cs[i]);
            e = sb.pop_front();
            checks++;
            if (stateA !== e.st || illA !== e.ill || cntA !== e.cnt || haltA !== 1'b0) begin
                errors++;
                $display("FAIL illegal_skip cyc%0d: got st=%0d ill=%b cnt=%0d halt=%b, want st=%0d ill=%b cnt=%0d halt=0",
                         i, stateA, illA, cntA, haltA, e.st, e.ill, e.cnt);
            end
            // The halting instance pulses once, then sits in fetch for good
            if (i >= 1) begin
                checks++;
                if (stateB !== 6'd0 || illB !== (i == 1) || haltB !== 1'b1 || cntB !== 32'd5) begin
                    errors++;
                    $display("FAIL illegal_halt cyc%0d: got st=%0d ill=%b halt=%b cnt=%0d, want st=0 ill=%b halt=1 cnt=5",
                             i, stateB, illB, haltB, cntB, (i == 1));
                end
            end
        end
    endtask

    task automatic test_run_stall();
        cyc_t cs[$];
        exp_t e;
        cs.push_back(cy(0, 1, 1, OP_R, S_DECODE, 0, 6));
        cs.push_back(cy(0, 1, 1, OP_R, S_REXEC,  0, 6));
        for (int k = 0; k < 5; k++)
            cs.push_back(cy(0, 0, (k % 2 == 0), OP_R, S_REXEC, 0, 6));
        cs.push_back(cy(0, 1, 0, OP_R, S_RWB,    0, 6));
        cs.push_back(cy(0, 1, 0, OP_R, S_FETCH,  0, 7));
        // A completion seen while frozen must not be consumed later
        cs.push_back(cy(0, 0, 1, OP_R, S_FETCH,  0, 7));
        cs.push_back(cy(0, 1, 0, OP_R, S_FETCH,  0, 7));
        foreach (cs[i]) begin
            apply_cycle(cs[i]);
            e = sb.pop_front();
            checks++;
            if (stateA !== e.st || illA !== e.ill || cntA !== e.cnt || haltA !== 1'b0) begin
                errors++;
                $display("FAIL run_stall cyc%0d: got st=%0d ill=%b cnt=%0d halt=%b, want st=%0d ill=%b cnt=%0d halt=0",
                         i, stateA, illA, cntA, haltA, e.st, e.ill, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc_t cs[$];
        exp_t e;
        cs.push_back(cy(0, 1, 1, OP_LW, S_DECODE, 0, 7));
        cs.push_back(cy(0, 1, 1, OP_LW, S_MADDR,  0, 7));
        cs.push_back(cy(0, 1, 1, OP_LW, S_LWRD,   0, 7));
        cs.push_back(cy(0, 1, 0, OP_LW, S_LWRD,   0, 7));
        cs.push_back(cy(1, 1, 1, OP_LW, S_FETCH,  0, 0));
        cs.push_back(cy(0, 1, 0, OP_LW, S_FETCH,  0, 0));
        foreach (cs[i]) begin
            apply_cycle(cs[i]);
            e = sb.pop_front();
            checks++;
            if (stateA !== e.st || illA !== e.ill || cntA !== e.cnt || haltA !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid cyc%0d: got st=%0d ill=%b cnt=%0d halt=%b, want st=%0d ill=%b cnt=%0d halt=0",
                         i, stateA, illA, cntA, haltA, e.st, e.ill, e.cnt);
            end
        end
        checks++;
        if (stateB !== 6'd0 || haltB !== 1'b0 || cntB !== 32'd0) begin
            errors++;
            $display("FAIL reset_clears_halt: got st=%0d halt=%b cnt=%0d, want st=0 halt=0 cnt=0",
                     stateB, haltB, cntB);
        end
    endtask

    task automatic test_wrap();
        cyc_t cs[$];
        exp_t e;
        for (int k = 1; k <= 16; k++) begin
            cs.push_back(cy(0, 1, 1, OP_J, S_DECODE, 0, 4'(k - 1)));
            cs.push_back(cy(0, 1, 1, OP_J, S_JUMP,   0, 4'(k - 1)));
            cs.push_back(cy(0, 1, 1, OP_J, S_FETCH,  0, 4'(k)));
        end
        foreach (cs[i]) begin
            apply_cycle(cs[i]);
            e = sb.pop_front();
            checks++;
            if (stateA !== e.st || illA !== e.ill || cntA !== e.cnt || haltA !== 1'b0) begin
                errors++;
                $display("FAIL wrap cyc%0d: got st=%0d ill=%b cnt=%0d halt=%b, want st=%0d ill=%b cnt=%0d halt=0",
                         i, stateA, illA, cntA, haltA, e.st, e.ill, e.cnt);
            end
        end
        checks++;
        if (stateB !== 6'd0 || haltB !== 1'b0 || cntB !== 32'd16) begin
            errors++;
            $display("FAIL wide_count: got st=%0d halt=%b cnt=%0d, want st=0 halt=0 cnt=16",
                     stateB, haltB, cntB);
        end
    endtask

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        opcode    = OP_R;
        test_reset();
        test_r_type();
        test_lw_stall();
        test_back_to_back();
        test_illegal();
        test_run_stall();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_control_sequencer.md
Name: mips_control_sequencer

Overview:
- Sequential next-state engine for the multi-cycle MIPS32 control unit.
- Holds the current control-state number and walks it through the ten-state fetch/decode/execute FSM from the instruction opcode.
- Feeds the existing combinational control-signal decoder via the 6-bit state bus; the decoder's op input is driven by this block's state output.
- Adds memory-wait stalling, run/halt gating, illegal-opcode detection and a retired-instruction counter.

Parameters:
- STATE_W, 6, width of the state bus; must match the decoder's op input.
- COUNT_W, 32, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 0, 1 = illegal opcode sets sticky halt; 0 = skip the instruction and refetch.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  1 = sequencer may advance; 0 = freeze all state.
- opcode  input  6  instruction[31:26] from the instruction register; valid from state 1 onward.
- mem_ready  input  1  memory completed this cycle's access.
- state  output  STATE_W  current control state, to the decoder's op input.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- halted  output  1  sticky halt flag; only used when HALT_ON_ILLEGAL=1.
- instr_retired  output  COUNT_W  count of completed instructions.

Behaviour:
- Reset is synchronous, active-high and dominates every other input. The next edge forces state=0, illegal_op=0, halted=0, instr_retired=0. This applies mid-instruction too: no partial completion is counted.
- All outputs are registered and change only on the rising edge of clk.
- State encoding:
  - 0 fetch
  - 1 decode
  - 2 R-exec
  - 3 R-writeback
  - 4 BEQ
  - 5 mem-address
  - 6 SW-write
  - 7 LW-read
  - 8 LW-writeback
  - 9 jump
- Transitions, when run=1 and halted=0:
  - 0 -> 1 if mem_ready, else stay in 0.
  - 1 dispatches on opcode:
    - 6'b000000 -> 2
    - 6'b100011 (LW) -> 5
    - 6'b101011 (SW) -> 5
    - 6'b000100 (BEQ) -> 4
    - 6'b000010 (J) -> 9
    - anything else is illegal.
  - 2 -> 3; 3 -> 0.
  - 4 -> 0.
  - 5 -> 7 if opcode is LW, -> 6 if opcode is SW.
  - 6 -> 0 if mem_ready, else stay in 6.
  - 7 -> 8 if mem_ready, else stay in 7.
  - 8 -> 0.
  - 9 -> 0.
  - Any unreachable encoding (10..2^STATE_W-1) -> 0 on the next edge, without counting or flagging.
- Latency in cycles, excluding memory waits: R-type 4, LW 5, SW 4, BEQ 3, J 3.
- Illegal opcode in state 1:
  - illegal_op=1 for exactly one cycle, aligned with the state register changing to 0.
  - HALT_ON_ILLEGAL=0: next state 0 and the instruction is not counted.
  - HALT_ON_ILLEGAL=1: next state 0 and halted=1. The block then holds state 0 until reset, with mem_ready and run ignored.
- run=0: state, counter and halted hold; illegal_op is 0. run=0 dominates a simultaneous mem_ready, so a memory completion arriving while run=0 is not consumed.
- Retirement: instr_retired increments by 1 on every edge where state leaves 3, 4, 8 or 9 for 0, or leaves 6 for 0 with mem_ready=1. It wraps modulo 2^COUNT_W with no saturation.
- opcode is only sampled in states 1 and 5; its value in other states is don't-care.

Test Plan:
- Reset, then run=1, mem_ready=1, opcode=000000 -> state sequence 0,1,2,3,0; instr_retired=1 on the fourth edge.
- LW (100011) with mem_ready held low 3 cycles during state 7 -> sequence 0,1,5,7,7,7,7,8,0; count increments once.
- SW then BEQ (000100) then J (000010), back to back -> states 0,1,5,6,0,1,4,0,1,9,0; instr_retired=3.
- Opcode 111111 in state 1, HALT_ON_ILLEGAL=0 -> illegal_op pulses one cycle, state returns to 0, count unchanged. With HALT_ON_ILLEGAL=1 -> halted=1 and state stuck at 0 until reset.
- run dropped during state 2 for 5 cycles with mem_ready=1 toggling -> state holds at 2, then resumes 3,0 when run=1.
- reset asserted for one edge while in state 7 -> state=0 and instr_retired=0 next cycle. Preload the count to 2^COUNT_W-1 by running instructions (reduced COUNT_W=4) -> the 16th retirement wraps the count to 0.
